// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  // funct3 encodings of the M-extension ops.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;
  localparam logic [31:0] DIV0_Q    = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_sign_adj.sv
// muldiv_sign_adj: operand magnitude extraction and result negation.
// The operand half is used at acceptance, the negation half on the final
// iteration, so one instance serves both ends of an operation.
module muldiv_sign_adj
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_e        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  input  logic [2*XLEN-1:0] val,
  input  logic              neg,
  output logic [2*XLEN-1:0] val_adj
);

  logic a_signed;
  logic b_signed;

  // Signedness per op, magnitudes, and two's-complement result fix-up.
  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    val_adj  = neg ? -val : val;
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer beside the EX ALU.
// Optional build macro MULDIV_FAST_MUL_EN: MUL* ops finish in one cycle using
// a combinational multiplier; divides always iterate.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int            CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  muldiv_state_e     state, state_nxt;
  muldiv_op_e        op_in, op_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_nxt;      // mul: {hi, lo/multiplier}; div: {rem, quotient}
  logic [XLEN-1:0]   opnd;              // multiplicand or divisor magnitude
  logic              res_neg_q;
  logic              accept, div_zero, div_ovf, special, fast_mul, res_neg_in;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, fast_res, final_res;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] adj_val, val_adj;
  logic [XLEN:0]     add_sum, trial, diff;

  assign op_in  = muldiv_op_e'(funct3_i);
  assign accept = (state == ST_IDLE) & start_i & ~flush_i;

  muldiv_sign_adj #(.XLEN(XLEN)) u_sign_adj (
    .op      (op_in),
    .a       (rs1_data_i),
    .b       (rs2_data_i),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .a_neg   (a_neg),
    .b_neg   (b_neg),
    .val     (adj_val),
    .neg     (res_neg_q),
    .val_adj (val_adj)
  );

  // Acceptance decode: special divide cases and the sign the result will need.
  always_comb begin
    div_zero    = op_in[2] && (rs2_data_i == '0);
    div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (rs1_data_i == INT_MIN) && (rs2_data_i == DIV0_Q);
    special     = div_zero | div_ovf;
    special_res = '0;
    if (div_zero)     special_res = op_in[1] ? rs1_data_i : DIV0_Q;
    else if (div_ovf) special_res = op_in[1] ? '0 : INT_MIN;
    res_neg_in  = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_prod;

  // Single-cycle product; the extra top bit carries each operand's sign.
  always_comb begin
    fast_a    = $signed({a_neg, rs1_data_i});
    fast_b    = $signed({b_neg, rs2_data_i});
    fast_prod = fast_a * fast_b;
    fast_mul  = ~op_in[2];
    fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    trial   = acc[2*XLEN-1:XLEN-1];
    diff    = trial - {1'b0, opnd};
    if (op_q[2])
      acc_nxt = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {add_sum, acc[XLEN-1:1]};
  end

  // Final result: the full product is negated as one 64-bit value so MULH
  // borrows correctly; divide results are negated as a single word.
  always_comb begin
    adj_val = acc_nxt;
    if (op_q[2])
      adj_val = {{XLEN{1'b0}}, (op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0])};
    final_res = ((op_q == OP_MUL) || op_q[2]) ? val_adj[XLEN-1:0] : val_adj[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; flush always wins.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = (special | fast_mul) ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush_i) state_nxt = ST_IDLE;
    stall_o = accept | (state == ST_CALC);
    busy_o  = (state != ST_IDLE);
    done_o  = (state == ST_DONE) & ~flush_i;
  end

  // Datapath: latch operands at acceptance, iterate in CALC, load result_o on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_q      <= OP_MUL;
      res_neg_q <= 1'b0;
      result_o  <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      res_neg_q <= res_neg_in;
      cnt       <= '0;
      if (op_in[2]) begin
        opnd <= b_mag;
        acc  <= {{XLEN{1'b0}}, a_mag};
      end else begin
        opnd <= a_mag;
        acc  <= {{XLEN{1'b0}}, b_mag};
      end
      if (special)       result_o <= special_res;
      else if (fast_mul) result_o <= fast_res;
    end else if (state == ST_CALC) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) result_o <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven vectors with a result scoreboard, plus hand
// sequences for flush, reset, start/flush collision and back-to-back ops.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res = '0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vt[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // start_i must never be raised while iterating; DONE is the only busy state where it may appear.
  always @(negedge clk) begin
    #1;
    if (start_i && busy_o && !done_o && !rst) begin
      fails++;
      $display("FAIL start_while_busy: start_i=1 with busy_o=1 outside DONE");
    end
  end

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    vt.push_back(v);
  endtask

  // Issue one op, scramble operands after acceptance, then pop and check on done_o.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int k;
    int stalls;
    logic got;
    logic [31:0] e;
    @(negedge clk);
    start_i = 1'b1; funct3_i = op; rs1_data_i = a; rs2_data_i = b;
    sb.push_back(exp);
    #1;
    stalls = stall_o ? 1 : 0;
    got = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      start_i = 1'b0;
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      #1;
      if (stall_o) stalls++;
      if (done_o) got = 1'b1;
    end
    if (got) begin
      if (sb.size() == 0) begin
        check({name, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({name, "_result"}, result_o, e);
        last_res = e;
      end
      check({name, "_latency"}, k, lat);
      check({name, "_stall_cycles"}, stalls, lat);
    end else begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    int seen;

    add_vec(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7_m3");
    add_vec(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, "mul_m1_m1");
    add_vec(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max");
    add_vec(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "mulh_m1_m1");
    add_vec(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1_max");
    add_vec(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min_min");
    add_vec(3'd3, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, MUL_LAT, "mulhu_shift");
    add_vec(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div_m7_2");
    add_vec(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem_m7_2");
    add_vec(3'd5, 32'd100,       32'd7,         32'd14,        33, "divu_100_7");
    add_vec(3'd7, 32'd100,       32'd7,         32'd2,         33, "remu_100_7");
    add_vec(3'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 33, "div_m7_m2");
    add_vec(3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, "rem_m7_m2");
    add_vec(3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
    add_vec(3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, "rem_7_m2");
    add_vec(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, "divu_max_1");
    add_vec(3'd7, 32'hFFFF_FFFF, 32'd10,        32'd5,         33, "remu_max_10");
    add_vec(3'd4, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 33, "div_min_1");
    add_vec(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "divu_min_max");
    add_vec(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "remu_min_max");
    add_vec(3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1, "divu_by0");
    add_vec(3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1, "remu_by0");
    add_vec(3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, "div_by0");
    add_vec(3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1, "rem_by0");
    add_vec(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    add_vec(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_done",   {31'd0, done_o},  32'd0);
    check("rst_busy",   {31'd0, busy_o},  32'd0);
    check("rst_stall",  {31'd0, stall_o}, 32'd0);
    check("rst_result", result_o,         32'd0);

    // Table-driven vectors.
    foreach (vt[i]) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, vt[i].name);

    // Flush in the middle of a divide: no done_o, back to IDLE, result_o kept.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd4; rs1_data_i = 32'd1000; rs2_data_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush_no_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_idle_busy",  {31'd0, busy_o},  32'd0);
    check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done_o) seen++;
    end
    check("flush_no_late_done", seen, 32'd0);
    check("flush_result_kept", result_o, last_res);

    run_op(3'd0, 32'd5, 32'd6, 32'd30, MUL_LAT, "mul_5_6_after_flush");

    // Reset mid-CALC abandons the divide and clears every output.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd5; rs1_data_i = 32'd1000; rs2_data_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_result", result_o,         32'd0);
    check("midrst_done",   {31'd0, done_o},  32'd0);
    check("midrst_busy",   {31'd0, busy_o},  32'd0);
    check("midrst_stall",  {31'd0, stall_o}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done_o) seen++;
    end
    check("midrst_no_done", seen, 32'd0);

    // start_i together with flush_i in IDLE is not accepted.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd5; rs1_data_i = 32'd9; rs2_data_i = 32'd2;
    #1;
    check("startflush_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("startflush_busy", {31'd0, busy_o}, 32'd0);

    // Back-to-back: a stray start during DONE is ignored, the op in the next cycle is taken.
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "b2b_first");
    start_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd3; rs2_data_i = 32'd3;
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "b2b_second");
    check("b2b_queue_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
